// File: rtl/frame_store_responder_pkg.sv
// Shared types for the frame-store responder: FSM states and posted-write FIFO entry.
// Latency: n/a (types only); backpressure: n/a.
package frame_store_responder_pkg;

   localparam int DE_WORD_W = 32;
   localparam int FS_ADDR_W = 18;
   localparam int NBYTE_W   = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRAIN,
      S_RISSUE,
      S_RWAIT,
      S_RACK
   } state_t;

   typedef struct packed {
      logic [FS_ADDR_W-1:0] addr;
      logic [NBYTE_W-1:0]   nbyte;
      logic [DE_WORD_W-1:0] data;
   } fifo_entry_t;

   // DE byte enables are active-low, SRAM byte enables active-high
   function automatic logic [NBYTE_W-1:0] nbyte_to_be(input logic [NBYTE_W-1:0] nbyte);
      return ~nbyte;
   endfunction

endpackage

// File: rtl/frame_store_responder_post_fifo.sv
// Posted-write FIFO: head visible combinationally, push lands one cycle later.
// Latency: 1 cycle push-to-head; backpressure: full blocks push, pop on empty ignored.
module post_fifo
   import frame_store_responder_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  fifo_entry_t push_dat,
   input  logic        pop,
   output fifo_entry_t head_dat,
   output logic        full,
   output logic        empty
);

   localparam int IW = $clog2(DEPTH);

   logic [IW:0] wr_ptr;
   logic [IW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;
   fifo_entry_t mem [DEPTH];

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign head_dat = mem[rd_ptr[IW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // storage needs no reset; pointers define what is valid
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[IW-1:0]] <= push_dat;
   end

endmodule

// File: rtl/frame_store_responder.sv
// DE frame-store responder: posts writes, orders reads behind them, shares SRAM with priority scan.
// Latency: write ack same cycle, read ack 3 cycles (empty FIFO), scan 2 cycles; backpressure: full FIFO or busy FSM holds de_ack low.
module frame_store_responder
   import frame_store_responder_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = FS_ADDR_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 de_req,
   output logic                 de_ack,
   input  logic [ADDR_W-1:0]    de_addr,
   input  logic [NBYTE_W-1:0]   de_nbyte,
   input  logic                 de_rnw,
   input  logic [DE_WORD_W-1:0] de_w_data,
   output logic [DE_WORD_W-1:0] de_r_data,
   input  logic                 scan_req,
   input  logic [ADDR_W-1:0]    scan_addr,
   output logic                 scan_valid,
   output logic [DE_WORD_W-1:0] scan_data,
   output logic                 sram_cs,
   output logic                 sram_we,
   output logic [NBYTE_W-1:0]   sram_be,
   output logic [ADDR_W-1:0]    sram_addr,
   output logic [DE_WORD_W-1:0] sram_wdata,
   input  logic [DE_WORD_W-1:0] sram_rdata
);

   state_t      state;
   state_t      state_nxt;
   logic        wr_ack;
   logic        fifo_push;
   logic        fifo_pop;
   logic        fifo_full;
   logic        fifo_empty;
   fifo_entry_t push_dat;
   fifo_entry_t head_dat;
   logic        scan_issue;
   logic        rd_issue;
   logic        drain_issue;
   logic        scan_inflight;

   // all-ones nbyte is a null write: acknowledged but never posted
   assign fifo_push = wr_ack && (de_nbyte != '1);
   assign push_dat  = '{addr: FS_ADDR_W'(de_addr), nbyte: de_nbyte, data: de_w_data};

   post_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_post_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (fifo_push),
      .push_dat(push_dat),
      .pop     (fifo_pop),
      .head_dat(head_dat),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // slot priority: scan, then DE read issue, then posted-write drain
   assign scan_issue  = rst_n && scan_req;
   assign rd_issue    = rst_n && !scan_req && (state == S_RISSUE);
   assign drain_issue = rst_n && !scan_req && (state != S_RISSUE) && !fifo_empty;
   assign fifo_pop    = drain_issue;

   always_comb begin
      sram_cs    = scan_issue || rd_issue || drain_issue;
      sram_we    = drain_issue;
      sram_be    = '0;
      sram_addr  = '0;
      sram_wdata = '0;
      if (scan_issue) begin
         sram_addr = scan_addr;
      end else if (rd_issue) begin
         sram_addr = de_addr;
      end else if (drain_issue) begin
         sram_addr  = ADDR_W'(head_dat.addr);
         sram_be    = nbyte_to_be(head_dat.nbyte);
         sram_wdata = head_dat.data;
      end
   end

   always_comb begin
      state_nxt = state;
      wr_ack    = rst_n && de_req && !de_rnw && !fifo_full && (state == S_IDLE);
      de_ack    = wr_ack || (state == S_RACK);
      unique case (state)
         // an empty FIFO has nothing to wait for, so go straight to issue
         S_IDLE:   if (rst_n && de_req && de_rnw) state_nxt = fifo_empty ? S_RISSUE : S_DRAIN;
         S_DRAIN:  if (fifo_empty) state_nxt = S_RISSUE;
         S_RISSUE: if (!scan_req) state_nxt = S_RWAIT;
         S_RWAIT:  state_nxt = S_RACK;
         S_RACK:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         de_r_data     <= '0;
         scan_inflight <= 1'b0;
         scan_valid    <= 1'b0;
         scan_data     <= '0;
      end else begin
         state         <= state_nxt;
         scan_inflight <= scan_issue;
         scan_valid    <= scan_inflight;
         if (scan_inflight)     scan_data <= sram_rdata;
         if (state == S_RWAIT)  de_r_data <= sram_rdata;
      end
   end

endmodule
